// File: rtl/cmos_pattern_tx_pkg.sv
// Shared types and constants for the CMOS test-pattern transmitter.
// The PRBS variant of mode 3 is enabled with CMOS_PATTERN_TX_PRBS_EN.
package cmos_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_CNT   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GAP    = 3'd1,
        ST_FRONT  = 3'd2,
        ST_LINE   = 3'd3,
        ST_HBLANK = 3'd4,
        ST_BACK   = 3'd5
    } state_e;

    // Wide enough for every timing parameter (largest default is V_GAP=4000).
    localparam int CNT_W = 16;

    // x^8+x^6+x^5+x^4+1 as Fibonacci taps on bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Bar colour table, {R,G,B} flags, bars left to right.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/cmos_pattern_tx_pix.sv
// Combinational pixel generator: Bayer RGGB value for (mode, x, y).
// With CMOS_PATTERN_TX_PRBS_EN, mode 3 passes the LFSR state through.
module cmos_pattern_pix
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  mode_e            mode,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic [7:0]       cval,
`ifdef CMOS_PATTERN_TX_PRBS_EN
    input  logic [7:0]       lfsr,
`endif
    output logic [7:0]       pix
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx;
    logic [2:0] rgb;
    logic       comp;

    always_comb begin
        bar_idx = 3'(32'(x) / 32'(BAR_W));
        rgb     = bar_rgb(bar_idx);
        // Even row carries R/G, odd row carries G/B.
        case ({y[0], x[0]})
            2'b00:   comp = rgb[2];
            2'b11:   comp = rgb[0];
            default: comp = rgb[1];
        endcase
    end

    always_comb begin
        pix = 8'h00;
        case (mode)
            MODE_BARS:  pix = comp ? 8'hFF : 8'h00;
            MODE_RAMP:  pix = 8'(x);
            MODE_CONST: pix = cval;
`ifdef CMOS_PATTERN_TX_PRBS_EN
            MODE_CNT:   pix = lfsr;
`else
            MODE_CNT:   pix = 8'(x) + 8'(y);
`endif
            default:    pix = 8'h00;
        endcase
    end

endmodule

// File: rtl/cmos_pattern_tx.sv
// 8-bit parallel CMOS sensor transmitter generating RGGB test frames.
// Optional PRBS mode 3 is selected with CMOS_PATTERN_TX_PRBS_EN.
module cmos_pattern_tx
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int H_BLANK  = 370,
    parameter int V_FRONT  = 16,
    parameter int V_BACK   = 16,
    parameter int V_GAP    = 4000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic        iEND,
    input  logic [1:0]  iMODE,
    input  logic [7:0]  iCONST,
    output logic [7:0]  oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic        oBUSY,
    output logic [31:0] oFrame_Cont
);

    localparam int X_W = $clog2(H_ACTIVE);
    localparam int Y_W = $clog2(V_ACTIVE + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [Y_W-1:0]   y_q, y_d;
    mode_e            mode_q, mode_d;
    logic [7:0]       const_q, const_d;
    logic [7:0]       data_q, data_d;
    logic             fval_q, fval_d;
    logic             lval_q, lval_d;
    logic             busy_q, busy_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic [7:0]       pix;
    logic             start_ok;
    logic             front_entry;
    logic             back_exit;

    assign start_ok    = iSTART && !iEND;
    assign front_entry = (state_q == ST_GAP)  && (cnt_q == CNT_W'(V_GAP - 1));
    assign back_exit   = (state_q == ST_BACK) && (cnt_q == CNT_W'(V_BACK - 1));

`ifdef CMOS_PATTERN_TX_PRBS_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (front_entry)
            lfsr_d = 8'hFF;
        else if (state_q == ST_LINE)
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) lfsr_q <= 8'h00;
        else         lfsr_q <= lfsr_d;
    end
`endif

    // State register and frame-scoped latches.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            y_q         <= '0;
            mode_q      <= MODE_BARS;
            const_q     <= 8'h00;
            data_q      <= 8'h00;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            const_q     <= const_d;
            data_q      <= data_d;
            fval_q      <= fval_d;
            lval_q      <= lval_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic; cnt_q is the clock count within the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                y_d   = '0;
                if (start_ok) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (front_entry) begin
                    state_d = ST_FRONT;
                    cnt_d   = '0;
                end
            end
            ST_FRONT: begin
                if (cnt_q == CNT_W'(V_FRONT - 1)) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                    y_d     = '0;
                end
            end
            ST_LINE: begin
                if (cnt_q == CNT_W'(H_ACTIVE - 1)) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                    y_d     = y_q + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (cnt_q == CNT_W'(H_BLANK - 1)) begin
                    state_d = (y_q == Y_W'(V_ACTIVE)) ? ST_BACK : ST_LINE;
                    cnt_d   = '0;
                end
            end
            ST_BACK: begin
                if (back_exit) begin
                    state_d = start_ok ? ST_GAP : ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    cmos_pattern_pix #(
        .H_ACTIVE (H_ACTIVE),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_pix (
        .mode (mode_q),
        .x    (cnt_q[X_W-1:0]),
        .y    (y_q),
        .cval (const_q),
`ifdef CMOS_PATTERN_TX_PRBS_EN
        .lfsr (lfsr_q),
`endif
        .pix  (pix)
    );

    // Output logic: registered one clock behind state and counters.
    always_comb begin
        mode_d      = front_entry ? mode_e'(iMODE) : mode_q;
        const_d     = front_entry ? iCONST : const_q;
        fval_d      = (state_q == ST_FRONT) || (state_q == ST_LINE) ||
                      (state_q == ST_HBLANK) || (state_q == ST_BACK);
        lval_d      = (state_q == ST_LINE);
        data_d      = lval_d ? pix : 8'h00;
        busy_d      = (state_q != ST_IDLE);
        frame_cnt_d = back_exit ? frame_cnt_q + 32'd1 : frame_cnt_q;
    end

    assign oDATA       = data_q;
    assign oFVAL       = fval_q;
    assign oLVAL       = lval_q;
    assign oBUSY       = busy_q;
    assign oFrame_Cont = frame_cnt_q;

endmodule

// File: tb/tb_cmos_pattern_tx.sv
// Directed bench for cmos_pattern_tx with a 16x4 frame geometry.
module tb_cmos_pattern_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [1:0]  mode;
    logic [7:0]  cval;
    logic [7:0]  oDATA;
    logic        oFVAL, oLVAL, oBUSY;
    logic [31:0] oFrame_Cont;

    int total = 0;
    int bad   = 0;

    // Per-frame capture results
    int         gap_len, f_hi, f_front, f_tail, n_lines, dz_viol, busy_viol;
    int         line_len  [8];
    int         blank_len [8];
    logic [7:0] pix [8][16];
    logic [7:0] sav [8][16];
    logic [7:0] bar0 [16];
    logic [7:0] bar1 [16];

    always #5 clk = ~clk;

    cmos_pattern_tx #(
        .H_ACTIVE (16),
        .V_ACTIVE (4),
        .H_BLANK  (4),
        .V_FRONT  (3),
        .V_BACK   (2),
        .V_GAP    (5)
    ) dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iSTART      (start),
        .iEND        (stop),
        .iMODE       (mode),
        .iCONST      (cval),
        .oDATA       (oDATA),
        .oFVAL       (oFVAL),
        .oLVAL       (oLVAL),
        .oBUSY       (oBUSY),
        .oFrame_Cont (oFrame_Cont)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for FVAL, then records one frame until FVAL falls.
    // Optionally changes iCONST or raises iEND once a given line is reached.
    task automatic run_frame(input int poke_line, input logic [7:0] poke_val, input int end_line);
        int  n = 0;
        int  x = 0;
        logic prev = 1'b0;
        while (!oFVAL && n < 200) begin
            n++;
            @(negedge clk);
        end
        gap_len = n;
        chk("fval_rise", oFVAL, 1'b1);
        f_hi = 0; f_front = 0; f_tail = 0; n_lines = 0; dz_viol = 0; busy_viol = 0;
        for (int i = 0; i < 8; i++) begin
            line_len[i] = 0;
            blank_len[i] = 0;
        end
        while (oFVAL && f_hi < 2000) begin
            f_hi++;
            if (n_lines == poke_line && oLVAL) cval = poke_val;
            if (n_lines == end_line) stop = 1'b1;
            if (!oBUSY) busy_viol++;
            if (oLVAL) begin
                if (!prev) begin
                    if (n_lines == 0) f_front = f_tail;
                    else if (n_lines <= 8) blank_len[n_lines-1] = f_tail;
                    x = 0;
                end
                if (n_lines < 8 && x < 16) pix[n_lines][x] = oDATA;
                x++;
            end else begin
                if (prev) begin
                    if (n_lines < 8) line_len[n_lines] = x;
                    n_lines++;
                    f_tail = 0;
                end
                f_tail++;
                if (oDATA !== 8'h00) dz_viol++;
            end
            prev = oLVAL;
            @(negedge clk);
        end
        chk("fval_fall", oFVAL, 1'b0);
        $display("frame %0d: gap=%0d fval_hi=%0d front=%0d lines=%0d tail=%0d mode=%0d",
                 oFrame_Cont, gap_len, f_hi, f_front, n_lines, f_tail, mode);
    endtask

    task automatic chk_shape(input string tag);
        chk({tag, "_fval_hi"}, f_hi, 85);
        chk({tag, "_front"}, f_front, 3);
        chk({tag, "_lines"}, n_lines, 4);
        chk({tag, "_tail"}, f_tail, 6);
        chk({tag, "_data_zero"}, dz_viol, 0);
        chk({tag, "_busy"}, busy_viol, 0);
    endtask

    initial begin
        int cnt;
        int rises;
        logic prev;
        bar0 = '{8'hFF,8'hFF, 8'hFF,8'hFF, 8'h00,8'hFF, 8'h00,8'hFF,
                 8'hFF,8'h00, 8'hFF,8'h00, 8'h00,8'h00, 8'h00,8'h00};
        bar1 = '{8'hFF,8'hFF, 8'hFF,8'h00, 8'hFF,8'hFF, 8'hFF,8'h00,
                 8'h00,8'hFF, 8'h00,8'h00, 8'h00,8'hFF, 8'h00,8'h00};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd1; cval = 8'h00;
        @(negedge clk); @(negedge clk);
        chk("rst_data", oDATA, 8'h00);
        chk("rst_fval", oFVAL, 1'b0);
        chk("rst_lval", oLVAL, 1'b0);
        chk("rst_busy", oBUSY, 1'b0);
        chk("rst_cnt", oFrame_Cont, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", oBUSY, 1'b0);

        // Frame 1: timing, ramp pattern
        start = 1'b1;
        run_frame(-1, 8'h00, -1);
        chk_shape("f1");
        for (int i = 0; i < 4; i++) chk("f1_line_len", line_len[i], 16);
        for (int i = 0; i < 3; i++) chk("f1_hblank", blank_len[i], 4);
        chk("f1_ramp_0_5", pix[0][5], 8'h05);
        chk("f1_ramp_3_15", pix[3][15], 8'h0F);
        chk("f1_frame_cnt", oFrame_Cont, 32'd1);
        mode = 2'd0;

        // Frame 2: colour bars
        run_frame(-1, 8'h00, -1);
        chk("f2_gap", gap_len, 5);
        chk_shape("f2");
        for (int i = 0; i < 16; i++) begin
            chk("f2_bar_line0", pix[0][i], bar0[i]);
            chk("f2_bar_line1", pix[1][i], bar1[i]);
        end
        chk("f2_bar_line2_px9", pix[2][9], 8'h00);
        chk("f2_frame_cnt", oFrame_Cont, 32'd2);
        mode = 2'd2; cval = 8'hA5;

        // Frame 3: constant, iCONST changed mid-frame has no effect
        run_frame(1, 8'h3C, -1);
        cnt = 0;
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 16; i++) if (pix[l][i] !== 8'hA5) cnt++;
        chk("f3_const_a5_bad_px", cnt, 0);
        chk_shape("f3");

        // Frame 4: picks up the new constant
        run_frame(-1, 8'h00, -1);
        cnt = 0;
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 16; i++) if (pix[l][i] !== 8'h3C) cnt++;
        chk("f4_const_3c_bad_px", cnt, 0);
        mode = 2'd3;

        // Frame 5: mode 3
        run_frame(-1, 8'h00, -1);
`ifdef CMOS_PATTERN_TX_PRBS_EN
        chk("f5_prbs_0", pix[0][0], 8'hFF);
        chk("f5_prbs_1", pix[0][1], 8'hFE);
        chk("f5_prbs_2", pix[0][2], 8'hFC);
        chk("f5_prbs_3", pix[0][3], 8'hF8);
        chk("f5_prbs_4", pix[0][4], 8'hF0);
        chk("f5_prbs_5", pix[0][5], 8'hE1);
`else
        chk("f5_cnt_0_0", pix[0][0], 8'h00);
        chk("f5_cnt_1_2", pix[1][2], 8'h03);
        chk("f5_cnt_3_15", pix[3][15], 8'h12);
`endif
        sav = pix;

        // Frame 6: mode 3 again, stop requested during line 2
        run_frame(-1, 8'h00, 2);
        chk_shape("f6");
`ifdef CMOS_PATTERN_TX_PRBS_EN
        cnt = 0;
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 16; i++) if (pix[l][i] !== sav[l][i]) cnt++;
        chk("f6_prbs_repeat_bad_px", cnt, 0);
`else
        chk("f6_cnt_2_7", pix[2][7], 8'h09);
        chk("f6_cnt_3_15", pix[3][15], sav[3][15]);
`endif
        chk("f6_frame_cnt", oFrame_Cont, 32'd6);

        // Start and stop both high: must stay idle
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (oFVAL) cnt++;
        end
        chk("stop_no_fval", cnt, 0);
        chk("stop_busy", oBUSY, 1'b0);
        chk("stop_frame_cnt", oFrame_Cont, 32'd6);

        // Reset asserted during line 1
        stop = 1'b0; mode = 2'd1;
        rises = 0; cnt = 0; prev = 1'b0;
        while (rises < 2 && cnt < 300) begin
            @(negedge clk);
            if (oLVAL && !prev) rises++;
            prev = oLVAL;
            cnt++;
        end
        chk("line1_reached", rises, 2);
        repeat (3) @(negedge clk);
        chk("pre_rst_lval", oLVAL, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_data", oDATA, 8'h00);
        chk("arst_fval", oFVAL, 1'b0);
        chk("arst_lval", oLVAL, 1'b0);
        chk("arst_busy", oBUSY, 1'b0);
        chk("arst_cnt", oFrame_Cont, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(-1, 8'h00, -1);
        chk_shape("f7");
        chk("f7_ramp_1_9", pix[1][9], 8'h09);
        chk("f7_frame_cnt", oFrame_Cont, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
